// File: rtl/board_level_data_receiver_link_pkg.sv
// Shared types, constants and the CRC-8 step for the link-layer receiver.
package board_level_data_receiver_link_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DROP_CRC      = 2'd0,
    DROP_OVERFLOW = 2'd1,
    DROP_FORMAT   = 2'd2,
    DROP_ABORT    = 2'd3
  } drop_reason_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // One byte through CRC-8, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/board_level_data_receiver_link_if.sv
// Byte stream leaving the receiver: valid/ready with a last-byte marker.
interface board_level_data_receiver_link_if;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_last, output m_valid, input m_ready);
  modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/board_level_data_receiver_frame_buffer.sv
// Commit/rollback FIFO: writes stay invisible to the reader until committed.
module board_level_data_receiver_frame_buffer
  import board_level_data_receiver_link_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  fifo_entry_t wr_entry,
  input  logic        commit,
  input  logic        rollback,
  input  logic        rd_en,
  output fifo_entry_t rd_entry,
  output logic        rd_valid,
  output logic        full
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [ADDR_W:0] wptr, cptr, rptr;
  fifo_entry_t     mem [DEPTH];
  logic            wr_fire, rd_fire;

  assign rd_valid = (rptr != cptr);
  assign rd_fire  = rd_en & rd_valid;
  // Full is MSBs differing with equal low bits; a read this cycle frees a slot.
  assign full     = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && !rd_fire;
  assign wr_fire  = wr_en & ~full & ~rollback;
  assign rd_entry = mem[rptr[ADDR_W-1:0]];

  // Storage array write.
  // NOTE: the data array has no reset; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wptr[ADDR_W-1:0]] <= wr_entry;
  end

  // Pointer update: rollback rewinds writes, commit publishes them (incl. this cycle's write).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      cptr <= '0;
      rptr <= '0;
    end else begin
      if (rd_fire) rptr <= rptr + PTR_ONE;
      if (rollback)     wptr <= cptr;
      else if (wr_fire) wptr <= wptr + PTR_ONE;
      if (commit) cptr <= wr_fire ? (wptr + PTR_ONE) : wptr;
    end
  end

endmodule

// File: rtl/board_level_data_receiver_link.sv
// Link receiver: packs 6-bit symbols into bytes, checks CRC-8, releases good frames.
module board_level_data_receiver_link
  import board_level_data_receiver_link_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic                             frame_end,
  input  logic [5:0]                       data,
  input  logic                             valid,
  board_level_data_receiver_link_if.master m,
  output logic                             frame_ok,
  output logic                             frame_drop,
  output logic [1:0]                       drop_reason
);

  state_t       state, state_d;
  logic [12:0]  acc, acc_d;
  logic [3:0]   cnt, cnt_d;
  logic [7:0]   h1, h1_d, h0, h0_d;
  logic [1:0]   nb, nb_d;          // bytes seen this frame, saturating at 2
  logic [7:0]   crc, crc_d;
  logic         ovf, ovf_d;
  logic         ok_q, ok_d, drop_q, drop_d;
  drop_reason_t reason_q, reason_d;

  logic         is_start, is_end, is_data;
  logic [12:0]  sh;
  logic [3:0]   cnt_sh;
  logic         byte_rdy, resid_nz;
  logic [7:0]   new_byte;

  logic         wr_en, commit, rollback, full;
  fifo_entry_t  wr_entry, rd_entry;

  assign is_start = valid & frame_start;
  assign is_end   = valid & frame_end & ~frame_start;
  assign is_data  = valid & ~frame_start & ~frame_end;

  assign sh       = {acc[6:0], data};
  assign cnt_sh   = cnt + 4'd6;
  assign byte_rdy = (cnt_sh >= 4'd8);
  assign new_byte = 8'(sh >> (cnt_sh - 4'd8));
  assign resid_nz = |(acc & ((13'd1 << cnt) - 13'd1));

  // Next-state, packer, hold-back pipeline and close decision.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    h1_d     = h1;
    h0_d     = h0;
    nb_d     = nb;
    crc_d    = crc;
    ovf_d    = ovf;
    ok_d     = 1'b0;
    drop_d   = 1'b0;
    reason_d = reason_q;
    wr_en    = 1'b0;
    wr_entry = '0;
    commit   = 1'b0;
    rollback = 1'b0;

    unique case (state)
      IDLE: if (is_start) state_d = RECV;
      RECV: begin
        if (is_start) begin
          drop_d   = 1'b1;
          reason_d = DROP_ABORT;
          rollback = 1'b1;
        end else if (is_end) begin
          state_d = CLOSE;
        end else if (is_data) begin
          acc_d = sh;
          cnt_d = cnt_sh;
          if (byte_rdy) begin
            cnt_d = cnt_sh - 4'd8;
            if (nb == 2'd2) begin
              wr_en         = 1'b1;
              wr_entry.data = h1;
              crc_d         = crc8_step(crc, h1);
              ovf_d         = ovf | full;
            end
            h1_d = h0;
            h0_d = new_byte;
            nb_d = (nb == 2'd2) ? 2'd2 : nb + 2'd1;
          end
        end
      end
      CLOSE: begin
        state_d = is_start ? RECV : IDLE;
        if (ovf) begin
          drop_d = 1'b1; reason_d = DROP_OVERFLOW;
        end else if (nb != 2'd2 || resid_nz) begin
          drop_d = 1'b1; reason_d = DROP_FORMAT;
        end else if (crc8_step(crc, h1) != h0) begin
          drop_d = 1'b1; reason_d = DROP_CRC;
        end else if (full) begin
          drop_d = 1'b1; reason_d = DROP_OVERFLOW;
        end else begin
          wr_en         = 1'b1;
          wr_entry.last = 1'b1;
          wr_entry.data = h1;
          commit        = 1'b1;
          ok_d          = 1'b1;
        end
        rollback = drop_d;
      end
      default: state_d = IDLE;
    endcase

    // A new frame (or leaving CLOSE) starts from a clean context.
    if ((state == IDLE && is_start) || (state == RECV && is_start) || state == CLOSE) begin
      acc_d = '0;
      cnt_d = '0;
      h1_d  = '0;
      h0_d  = '0;
      nb_d  = '0;
      crc_d = CRC8_INIT;
      ovf_d = 1'b0;
    end
  end

  // Frame context and status pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      h1       <= '0;
      h0       <= '0;
      nb       <= '0;
      crc      <= CRC8_INIT;
      ovf      <= 1'b0;
      ok_q     <= 1'b0;
      drop_q   <= 1'b0;
      reason_q <= DROP_CRC;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      cnt      <= cnt_d;
      h1       <= h1_d;
      h0       <= h0_d;
      nb       <= nb_d;
      crc      <= crc_d;
      ovf      <= ovf_d;
      ok_q     <= ok_d;
      drop_q   <= drop_d;
      reason_q <= reason_d;
    end
  end

  board_level_data_receiver_frame_buffer #(.ADDR_W(ADDR_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (m.m_ready),
    .rd_entry (rd_entry),
    .rd_valid (m.m_valid),
    .full     (full)
  );

  assign m.m_data    = rd_entry.data;
  assign m.m_last    = rd_entry.last;
  assign frame_ok    = ok_q;
  assign frame_drop  = drop_q;
  assign drop_reason = reason_q;

endmodule

// File: tb/tb_board_level_data_receiver_link.sv
// Scoreboard bench for the link receiver: expected beats/events queued at stimulus time.
`timescale 1ns/1ps
module tb_board_level_data_receiver_link;

  localparam int ADDR_W = 3;
  localparam int EVT_OK = 4;

  typedef logic [7:0] byte_q_t [$];
  typedef logic [5:0] sym_q_t [$];

  logic       clk;
  logic       rst_n;
  logic       frame_start, frame_end, valid;
  logic [5:0] data;
  logic       frame_ok, frame_drop;
  logic [1:0] drop_reason;
  logic       toggle_ready;

  int checks = 0;
  int errors = 0;
  int beat_q [$];
  int evt_q  [$];

  board_level_data_receiver_link_if bus ();

  board_level_data_receiver_link #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .data        (data),
    .valid       (valid),
    .m           (bus),
    .frame_ok    (frame_ok),
    .frame_drop  (frame_drop),
    .drop_reason (drop_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial CRC-8 reference (poly 0x07, init 0).
  function automatic logic [7:0] ref_crc8(input byte_q_t b);
    logic [7:0] c = 8'h00;
    logic fb;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic drive(input logic s, input logic e, input logic [5:0] d, input logic v);
    frame_start = s;
    frame_end   = e;
    data        = d;
    valid       = v;
    if (toggle_ready) bus.m_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'h00, 1'b0);
  endtask

  task automatic send_syms(input sym_q_t s);
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    foreach (s[i]) drive(1'b0, 1'b0, s[i], 1'b1);
    drive(1'b0, 1'b1, 6'h00, 1'b1);
  endtask

  // Payload + correct CRC, zero-padded to whole symbols; no idle cycles added.
  task automatic send_frame(input byte_q_t pl, input int exp_evt);
    logic       bits [$];
    logic [7:0] all  [$];
    logic [5:0] sym;
    all = pl;
    all.push_back(ref_crc8(pl));
    foreach (all[i]) for (int k = 7; k >= 0; k--) bits.push_back(all[i][k]);
    while (bits.size() % 6 != 0) bits.push_back(1'b0);
    if (exp_evt == EVT_OK)
      foreach (pl[i]) beat_q.push_back(int'({(i == pl.size() - 1), pl[i]}));
    evt_q.push_back(exp_evt);
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < bits.size(); i += 6) begin
      for (int k = 0; k < 6; k++) sym[5-k] = bits[i+k];
      drive(1'b0, 1'b0, sym, 1'b1);
    end
    drive(1'b0, 1'b1, 6'h00, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((beat_q.size() != 0 || evt_q.size() != 0) && n < 300) begin
      idle(1);
      n++;
    end
    check({tag, "_beats_left"}, beat_q.size(), 0);
    check({tag, "_evts_left"}, evt_q.size(), 0);
  endtask

  // Output monitor: compares accepted beats and status pulses against the scoreboard.
  initial begin
    int got;
    forever begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        got = int'({bus.m_last, bus.m_data});
        if (beat_q.size() == 0) check("beat_unexpected", got, -1);
        else check("beat", got, beat_q.pop_front());
      end
      if (frame_ok || frame_drop) begin
        got = (frame_ok && frame_drop) ? 99 : (frame_ok ? EVT_OK : int'(drop_reason));
        if (evt_q.size() == 0) check("evt_unexpected", got, -1);
        else check("evt", got, evt_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    sym_q_t  s;
    byte_q_t pl;

    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; data = 6'h00; valid = 1'b0;
    bus.m_ready = 1'b1; toggle_ready = 1'b0;
    idle(3);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_frame_ok", int'(frame_ok), 0);
    check("rst_frame_drop", int'(frame_drop), 0);
    check("rst_drop_reason", int'(drop_reason), 0);
    rst_n = 1'b1;
    idle(2);

    // Good frame: bytes 0x01 (payload), 0x07 (CRC), 2 zero pad bits.
    beat_q.push_back(int'({1'b1, 8'h01}));
    evt_q.push_back(EVT_OK);
    s = '{6'h00, 6'h10, 6'h1C};
    send_syms(s);
    check("lat_after_end", int'(bus.m_valid), 0);
    idle(1);
    check("lat_plus2", int'(bus.m_valid), 1);
    check("ok_pulse", int'(frame_ok), 1);
    wait_drain("good");

    // Nonzero pad bits -> format drop.
    evt_q.push_back(2);
    s = '{6'h00, 6'h10, 6'h1D};
    send_syms(s);
    idle(3);
    check("fmt_no_beat", int'(bus.m_valid), 0);

    // Bytes 0x01, 0x06 -> CRC drop.
    evt_q.push_back(0);
    s = '{6'h00, 6'h10, 6'h18};
    send_syms(s);
    idle(3);
    check("crc_no_beat", int'(bus.m_valid), 0);
    wait_drain("drops");

    // Abort mid-frame, then the good frame.
    evt_q.push_back(3);
    evt_q.push_back(EVT_OK);
    beat_q.push_back(int'({1'b1, 8'h01}));
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    drive(1'b0, 1'b0, 6'h05, 1'b1);
    drive(1'b0, 1'b0, 6'h22, 1'b1);
    s = '{6'h00, 6'h10, 6'h1C};
    send_syms(s);
    wait_drain("abort");

    // Overflow: 10-byte payload into an 8-entry FIFO with no reads.
    bus.m_ready = 1'b0;
    pl = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
    send_frame(pl, 1);
    idle(3);
    check("ovf_fifo_empty", int'(bus.m_valid), 0);
    bus.m_ready = 1'b1;
    pl = '{8'hA5};
    send_frame(pl, EVT_OK);
    wait_drain("ovf");

    // Back-to-back frames, frame_start in the CLOSE cycle, ready toggling.
    toggle_ready = 1'b1;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, EVT_OK);
    pl = '{8'hC4, 8'h5E};
    send_frame(pl, EVT_OK);
    pl = '{8'h7F};
    send_frame(pl, EVT_OK);
    idle(12);
    toggle_ready = 1'b0;
    bus.m_ready  = 1'b1;
    wait_drain("b2b");

    // Reset mid-frame with committed beats pending.
    bus.m_ready = 1'b0;
    pl = '{8'h3C, 8'h4D, 8'h5E};
    send_frame(pl, EVT_OK);
    idle(3);
    check("pending_before_rst", int'(bus.m_valid), 1);
    drive(1'b1, 1'b0, 6'h00, 1'b1);
    drive(1'b0, 1'b0, 6'h2A, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 6'h15, 1'b1);
    check("rst_mid_m_valid", int'(bus.m_valid), 0);
    beat_q.delete();
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    idle(2);
    pl = '{8'h9B, 8'h01};
    send_frame(pl, EVT_OK);
    wait_drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
